// File: rtl/match_lock_detector.sv
// match_lock_detector
// Consumes one comparator equality bit per qualified cycle and tracks whether
// the two compared streams are in sustained agreement. Lock is acquired after
// LOCK_LEN consecutive matches and lost after MISS_LIMIT consecutive
// mismatches while locked. Single-cycle acquire/loss pulses are provided.
// Optional feature macro: MATCH_LOCK_STATS_EN builds a saturating count of
// matching samples on match_count; without it match_count is tied to zero.
module match_lock_detector #(
  parameter int LOCK_LEN   = 4,
  parameter int MISS_LIMIT = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_valid,
  input  logic             cmp_result,
  input  logic             clear,
  output logic             locked,
  output logic             lock_acq,
  output logic             lock_lost,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] match_count
);

  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_LEN);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] SLIP   = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [RUN_W-1:0]  run_reg, run_next;
  logic [MISS_W-1:0] miss_reg, miss_next;
  logic              locked_reg;
  logic              acq_reg, acq_next;
  logic              lost_reg, lost_next;

  // Next-state and event decode; clear overrides any sample this cycle.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    miss_next  = miss_reg;
    acq_next   = 1'b0;
    lost_next  = 1'b0;
    if (clear) begin
      state_next = SEARCH;
      run_next   = '0;
      miss_next  = '0;
    end else if (cmp_valid) begin
      case (state_reg)
        SEARCH: begin
          if (cmp_result) begin
            if (LOCK_LEN == 1) begin
              state_next = LOCKED;
              acq_next   = 1'b1;
              run_next   = '0;
            end else begin
              state_next = VERIFY;
              run_next   = RUN_W'(1);
            end
          end
        end
        VERIFY: begin
          if (cmp_result) begin
            if (run_reg + RUN_W'(1) == RUN_MAX) begin
              state_next = LOCKED;
              acq_next   = 1'b1;
              run_next   = '0;
            end else begin
              run_next = run_reg + RUN_W'(1);
            end
          end else begin
            // The mismatching sample does not seed a new run.
            state_next = SEARCH;
            run_next   = '0;
          end
        end
        LOCKED: begin
          if (!cmp_result) begin
            if (MISS_LIMIT == 1) begin
              state_next = SEARCH;
              lost_next  = 1'b1;
              miss_next  = '0;
            end else begin
              state_next = SLIP;
              miss_next  = MISS_W'(1);
            end
          end
        end
        default: begin
          if (cmp_result) begin
            // Any match forgives earlier misses.
            state_next = LOCKED;
            miss_next  = '0;
          end else if (miss_reg + MISS_W'(1) == MISS_MAX) begin
            state_next = SEARCH;
            lost_next  = 1'b1;
            miss_next  = '0;
          end else begin
            miss_next = miss_reg + MISS_W'(1);
          end
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= SEARCH;
      run_reg    <= '0;
      miss_reg   <= '0;
      locked_reg <= 1'b0;
      acq_reg    <= 1'b0;
      lost_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= run_next;
      miss_reg   <= miss_next;
      locked_reg <= (state_next == LOCKED) || (state_next == SLIP);
      acq_reg    <= acq_next;
      lost_reg   <= lost_next;
    end
  end

  assign state     = state_reg;
  assign locked    = locked_reg;
  assign lock_acq  = acq_reg;
  assign lock_lost = lost_reg;

`ifdef MATCH_LOCK_STATS_EN
  logic [CNT_W-1:0] count_reg;
  logic             match_hit;

  // A sample discarded by clear is not counted.
  assign match_hit = cmp_valid && cmp_result && !clear;

  // Saturating match counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (match_hit && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign match_count = count_reg;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_match_lock_detector.sv
// Scoreboard bench for match_lock_detector. Stimulus pushes expected outputs
// into a queue after each clock edge; a monitor pops and compares them on the
// following falling edge. A second instance with LOCK_LEN=1, MISS_LIMIT=1
// shares the same inputs to cover the single-sample lock/loss paths.
module tb_match_lock_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmp_valid = 1'b0;
  logic       cmp_result = 1'b0;
  logic       clear = 1'b0;
  logic       locked, lock_acq, lock_lost;
  logic [1:0] state;
  logic [3:0] match_count;
  logic       locked1, lock_acq1, lock_lost1;
  logic [1:0] state1;
  logic [3:0] match_count1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_vec    = 0;

  typedef struct {
    int         idx;
    logic [1:0] st;
    logic       lk;
    logic       acq;
    logic       lost;
    logic [3:0] cnt;
    logic [1:0] st1;
    logic       acq1;
    logic       lost1;
  } exp_t;

  exp_t exp_q[$];

  // Reference state kept by the bench
  logic [3:0] exp_cnt = 4'd0;
  logic       lock1   = 1'b0;

  match_lock_detector #(.LOCK_LEN(4), .MISS_LIMIT(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_result(cmp_result),
    .clear(clear), .locked(locked), .lock_acq(lock_acq), .lock_lost(lock_lost),
    .state(state), .match_count(match_count)
  );

  match_lock_detector #(.LOCK_LEN(1), .MISS_LIMIT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_result(cmp_result),
    .clear(clear), .locked(locked1), .lock_acq(lock_acq1), .lock_lost(lock_lost1),
    .state(state1), .match_count(match_count1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, req);
  endtask

  // Monitor: compare every expectation pushed since the last falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("state",       e.idx, int'(state),       int'(e.st));
      check("locked",      e.idx, int'(locked),      int'(e.lk));
      check("lock_acq",    e.idx, int'(lock_acq),    int'(e.acq));
      check("lock_lost",   e.idx, int'(lock_lost),   int'(e.lost));
      check("match_count", e.idx, int'(match_count), int'(e.cnt));
      check("l1_state",    e.idx, int'(state1),      int'(e.st1));
      check("l1_acq",      e.idx, int'(lock_acq1),   int'(e.acq1));
      check("l1_lost",     e.idx, int'(lock_lost1),  int'(e.lost1));
      $display("vec %0d: state=%0d locked=%0b acq=%0b lost=%0b cnt=%0d | l1 state=%0d",
               e.idx, state, locked, lock_acq, lock_lost, match_count, state1);
    end
  end

  // One clock of stimulus; the caller supplies the hand-derived expectations
  // for the LOCK_LEN=4 instance, the count and the LOCK_LEN=1 instance are
  // tracked here.
  task automatic step(input logic v, input logic r, input logic c,
                      input logic [1:0] st, input logic lk,
                      input logic acq, input logic lost);
    exp_t e;
    e.acq1  = 1'b0;
    e.lost1 = 1'b0;
    cmp_valid  = v;
    cmp_result = r;
    clear      = c;
    if (c) begin
      exp_cnt = 4'd0;
      lock1   = 1'b0;
    end else if (v) begin
`ifdef MATCH_LOCK_STATS_EN
      if (r && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
`endif
      if (r && !lock1) begin
        lock1  = 1'b1;
        e.acq1 = 1'b1;
      end else if (!r && lock1) begin
        lock1   = 1'b0;
        e.lost1 = 1'b1;
      end
    end
    @(posedge clk);
    e.idx  = n_vec;
    e.st   = st;
    e.lk   = lk;
    e.acq  = acq;
    e.lost = lost;
    e.cnt  = exp_cnt;
    e.st1  = lock1 ? 2'd2 : 2'd0;
    exp_q.push_back(e);
    n_vec++;
    #1;
  endtask

  task automatic check_all_zero(input int idx);
    check("rst_state",  idx, int'(state),       0);
    check("rst_locked", idx, int'(locked),      0);
    check("rst_acq",    idx, int'(lock_acq),    0);
    check("rst_lost",   idx, int'(lock_lost),   0);
    check("rst_count",  idx, int'(match_count), 0);
    check("rst_state1", idx, int'(state1),      0);
  endtask

  initial begin
    // Reset values while rst_n is held low
    #12;
    check_all_zero(-1);
    rst_n = 1'b1;

    // Acquire: 1,1,1,1 then an idle cycle
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd2, 1, 1, 0);
    step(0, 0, 0, 2'd2, 1, 0, 0);

    // Clear while locked (no sample), then mismatch in SEARCH stays put
    step(0, 0, 1, 2'd0, 0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0, 0);

    // Broken run: 1,1,1,0,1,1,1,1
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd2, 1, 1, 0);

    // Slip recovery and loss: 0,1,0,0
    step(1, 0, 0, 2'd3, 1, 0, 0);
    step(1, 1, 0, 2'd2, 1, 0, 0);
    step(1, 0, 0, 2'd3, 1, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0, 1);
    step(0, 0, 0, 2'd0, 0, 0, 0);

    // Relock, five idle cycles, then clear together with a matching sample
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd2, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'd2, 1, 0, 0);
    step(1, 1, 1, 2'd0, 0, 0, 0);

    // Enter SLIP, then clear: no loss pulse
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 2'd2, 1, 1, 0);
    step(1, 0, 0, 2'd3, 1, 0, 0);
    step(0, 0, 1, 2'd0, 0, 0, 0);

    // Saturation: 20 matches
    for (int i = 1; i <= 20; i++)
      step(1, 1, 0, (i < 4) ? 2'd1 : 2'd2, (i >= 4), (i == 4), 0);
    step(0, 0, 0, 2'd2, 1, 0, 0);

    // Asynchronous reset between edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero(-2);
    exp_cnt = 4'd0;
    lock1   = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, 2'd1, 0, 0, 0);
    step(0, 0, 0, 2'd1, 0, 0, 0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
